// File: rtl/pulse_stretcher_if.sv
// Event/level bundle between an event source and the pulse stretcher.
//   trig    : single-cycle event strobe (source -> stretcher)
//   ovf_clr : clears the sticky overflow flag (source -> stretcher)
//   O       : stretched output level (stretcher -> pin side)
//   busy    : stretcher is not idle
//   pend    : number of queued events
//   ovf     : sticky "event dropped" flag
interface pulse_stretcher_if #(
  parameter int unsigned PEND_WIDTH = 4
);
  logic                  trig;
  logic                  ovf_clr;
  logic                  O;
  logic                  busy;
  logic [PEND_WIDTH-1:0] pend;
  logic                  ovf;

  modport master (
    output trig,
    output ovf_clr,
    input  O,
    input  busy,
    input  pend,
    input  ovf
  );

  modport slave (
    input  trig,
    input  ovf_clr,
    output O,
    output busy,
    output pend,
    output ovf
  );
endinterface

// File: rtl/pulse_stretcher.sv
// Turns single-cycle event strobes into clean output pulses with a guaranteed
// minimum high time (ON_CYCLES) and minimum low gap (OFF_CYCLES). Events that
// arrive during a pulse or gap are queued in a saturating counter and replayed.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of pulse_stretcher_if (trig/ovf_clr in, O/busy/pend/ovf out)
module pulse_stretcher #(
  parameter int unsigned WIDTH      = 20,
  parameter int unsigned ON_CYCLES  = 500000,
  parameter int unsigned OFF_CYCLES = 500000,
  parameter int unsigned PEND_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  pulse_stretcher_if.slave   bus
);

  localparam logic [WIDTH-1:0]      ON_LAST  = WIDTH'(ON_CYCLES - 1);
  localparam logic [WIDTH-1:0]      OFF_LAST = WIDTH'(OFF_CYCLES - 1);
  localparam logic [PEND_WIDTH-1:0] PEND_MAX = {PEND_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      cnt_q, cnt_d;
  logic                  o_q, o_d;
  logic                  busy_q, busy_d;
  logic [PEND_WIDTH-1:0] pend_q, pend_d;
  logic                  ovf_q, ovf_d;

  logic on_last_c;
  logic gap_last_c;
  logic pend_nz_c;

  assign on_last_c  = (cnt_q == ON_LAST);
  assign gap_last_c = (cnt_q == OFF_LAST);
  assign pend_nz_c  = (pend_q != '0);

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      o_q     <= 1'b0;
      busy_q  <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next state and timing counter; the counter is always reloaded on a
  // terminal count so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.trig) begin
          state_d = ST_ON;
          cnt_d   = '0;
        end
      end
      ST_ON: begin
        if (on_last_c) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
      ST_GAP: begin
        if (gap_last_c) begin
          state_d = (pend_nz_c || bus.trig) ? ST_ON : ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered outputs, pending queue and overflow flag
  always_comb begin
    logic in_run;
    logic final_gap;
    logic pend_inc;
    logic pend_dec;
    logic ovf_set;

    o_d     = (state_d == ST_ON);
    busy_d  = (state_d != ST_IDLE);
    pend_d  = pend_q;
    ovf_set = 1'b0;

    in_run    = (state_q == ST_ON) || (state_q == ST_GAP);
    final_gap = (state_q == ST_GAP) && gap_last_c;
    // A trig on the last gap cycle with an empty queue launches the next
    // pulse directly and never enters the queue.
    pend_inc  = in_run && bus.trig && !(final_gap && !pend_nz_c);
    pend_dec  = final_gap && pend_nz_c;

    if (pend_inc && !pend_dec) begin
      if (pend_q == PEND_MAX) begin
        ovf_set = 1'b1;
      end else begin
        pend_d = pend_q + PEND_WIDTH'(1);
      end
    end else if (pend_dec && !pend_inc) begin
      pend_d = pend_q - PEND_WIDTH'(1);
    end

    // Set has priority over clear
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  assign bus.O    = o_q;
  assign bus.busy = busy_q;
  assign bus.pend = pend_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher with ON_CYCLES=4, OFF_CYCLES=3,
// PEND_WIDTH=2, WIDTH=4. Cycle 0 of each scenario is the cycle with trig=1.
module tb_pulse_stretcher;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;
  int   pulses;
  logic prev_o;

  pulse_stretcher_if #(.PEND_WIDTH(2)) ps_if ();

  pulse_stretcher #(
    .WIDTH      (4),
    .ON_CYCLES  (4),
    .OFF_CYCLES (3),
    .PEND_WIDTH (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ps_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Bounded wait for the stretcher to go idle
  task automatic drain();
    int n;
    n = 0;
    ps_if.trig    = 1'b0;
    ps_if.ovf_clr = 1'b0;
    while (ps_if.busy && n < 60) begin
      tick();
      n++;
    end
    chk("drain_idle", 32'(ps_if.busy), 32'd0);
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    rst_n = 1'b0;
    ps_if.trig    = 1'b0;
    ps_if.ovf_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_O",    32'(ps_if.O),    32'd0);
    chk("rst_busy", 32'(ps_if.busy), 32'd0);
    chk("rst_pend", 32'(ps_if.pend), 32'd0);
    chk("rst_ovf",  32'(ps_if.ovf),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single event
    cyc = 0;
    ps_if.trig = 1'b1;
    tick();
    ps_if.trig = 1'b0;
    while (cyc <= 8) begin
      chk("single_O",    32'(ps_if.O),    32'((cyc >= 1 && cyc <= 4) ? 1 : 0));
      chk("single_busy", 32'(ps_if.busy), 32'((cyc <= 7) ? 1 : 0));
      chk("single_pend", 32'(ps_if.pend), 32'd0);
      tick();
    end
    drain();

    // Back-to-back events
    cyc = 0;
    ps_if.trig = 1'b1;
    tick();
    tick();
    ps_if.trig = 1'b0;
    while (cyc <= 15) begin
      chk("b2b_O",    32'(ps_if.O),    32'(((cyc <= 4) || (cyc >= 8 && cyc <= 11)) ? 1 : 0));
      chk("b2b_busy", 32'(ps_if.busy), 32'((cyc <= 14) ? 1 : 0));
      chk("b2b_pend", 32'(ps_if.pend), 32'((cyc < 8) ? 1 : 0));
      tick();
    end
    drain();

    // Trig on the final gap cycle
    cyc = 0;
    ps_if.trig = 1'b1;
    tick();
    while (cyc <= 12) begin
      chk("lastgap_O",    32'(ps_if.O),    32'(((cyc <= 4) || (cyc >= 8 && cyc <= 11)) ? 1 : 0));
      chk("lastgap_pend", 32'(ps_if.pend), 32'd0);
      ps_if.trig = (cyc == 7);
      tick();
    end
    drain();

    // Saturation and overflow flag
    cyc    = 0;
    pulses = 0;
    prev_o = 1'b0;
    while (cyc <= 30) begin
      if (ps_if.O && !prev_o) pulses++;
      prev_o = ps_if.O;
      case (cyc)
        4:  chk("sat_pend_full", 32'(ps_if.pend), 32'd3);
        5:  chk("sat_ovf_pre",   32'(ps_if.ovf),  32'd0);
        6:  chk("sat_ovf_set",   32'(ps_if.ovf),  32'd1);
        7:  chk("sat_ovf_setwin", 32'(ps_if.ovf), 32'd1);
        8: begin
          chk("sat_ovf_clr", 32'(ps_if.ovf),  32'd0);
          chk("sat_pend_8",  32'(ps_if.pend), 32'd2);
        end
        15: chk("sat_pend_15", 32'(ps_if.pend), 32'd1);
        22: chk("sat_pend_22", 32'(ps_if.pend), 32'd0);
        28: chk("sat_busy_28", 32'(ps_if.busy), 32'd1);
        29: chk("sat_busy_29", 32'(ps_if.busy), 32'd0);
        default: ;
      endcase
      ps_if.trig    = (cyc <= 3) || (cyc == 5) || (cyc == 6);
      ps_if.ovf_clr = (cyc == 6) || (cyc == 7);
      tick();
    end
    chk("sat_pulses", 32'(pulses), 32'd4);
    drain();

    // Reset mid-pulse
    cyc = 0;
    ps_if.trig = 1'b1;
    tick();
    chk("rstmid_O1", 32'(ps_if.O), 32'd1);
    tick();
    ps_if.trig = 1'b0;
    chk("rstmid_pend2", 32'(ps_if.pend), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_O",    32'(ps_if.O),    32'd0);
    chk("rstmid_busy", 32'(ps_if.busy), 32'd0);
    chk("rstmid_pend", 32'(ps_if.pend), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    cyc = 0;
    ps_if.trig = 1'b1;
    tick();
    ps_if.trig = 1'b0;
    while (cyc <= 5) begin
      chk("rstmid_after_O", 32'(ps_if.O), 32'((cyc <= 4) ? 1 : 0));
      tick();
    end
    drain();

    // Decrement and trig in the same final gap cycle
    cyc = 0;
    ps_if.trig = 1'b1;
    tick();
    tick();
    tick();
    ps_if.trig = 1'b0;
    chk("simul_pend3", 32'(ps_if.pend), 32'd2);
    while (cyc < 7) tick();
    chk("simul_O7",    32'(ps_if.O),    32'd0);
    chk("simul_pend7", 32'(ps_if.pend), 32'd2);
    ps_if.trig = 1'b1;
    tick();
    ps_if.trig = 1'b0;
    chk("simul_O8",    32'(ps_if.O),    32'd1);
    chk("simul_pend8", 32'(ps_if.pend), 32'd2);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Output-side counterpart to the team's input debouncer.
- Takes single-cycle internal event strobes and drives an external-facing level (LED, buzzer, opto, slow peripheral strobe).
- Each event becomes a clean pulse with a guaranteed minimum high time and minimum low gap, so no glitches or short pulses reach the pins.
- Events arriving while a pulse or gap is in progress are queued in a saturating pending counter and replayed in order.

Parameters:
- WIDTH, 20, width of the timing counter; ON_CYCLES and OFF_CYCLES must be less than or equal to 2^WIDTH.
- ON_CYCLES, 500000, number of clk cycles O is held high per pulse; must be at least 1.
- OFF_CYCLES, 500000, minimum number of clk cycles O is held low between consecutive pulses; must be at least 1.
- PEND_WIDTH, 4, width of the pending-event counter; saturates at 2^PEND_WIDTH-1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- trig  input  1  event strobe, sampled every rising edge; each high cycle is one event.
- ovf_clr  input  1  clears the sticky overflow flag.
- O  output  1  stretched output level, registered.
- busy  output  1  high while state is not IDLE.
- pend  output  PEND_WIDTH  number of queued events, registered.
- ovf  output  1  sticky flag: an event was dropped because pend was saturated.

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-low on rst_n.
- Reset values while rst_n=0: state=IDLE, cnt=0, O=0, busy=0, pend=0, ovf=0. Reset takes effect immediately, including mid-pulse (O drops without completing ON_CYCLES).
- All outputs are registered. O is 1 exactly when state=ON.
- States: IDLE, ON, GAP. cnt is a WIDTH-bit counter.
- IDLE:
  - trig=1: next state ON, cnt=0. O rises on the edge that samples trig (1-cycle latency).
  - pend stays unchanged (always 0 in IDLE).
- ON:
  - cnt increments each cycle.
  - When cnt==ON_CYCLES-1: next state GAP, cnt=0. O is therefore high for exactly ON_CYCLES cycles.
- GAP:
  - cnt increments each cycle.
  - When cnt==OFF_CYCLES-1:
    - if pend>0 or trig=1: next state ON, cnt=0;
    - otherwise: next state IDLE.
  - O is therefore low for at least OFF_CYCLES cycles.
- Pending queue (trig in ON or GAP):
  - Each trig=1 cycle in ON or GAP, except the case below, increments pend.
  - Exception: trig on the final GAP cycle with pend=0 goes straight to ON and consumes the event without touching pend.
  - Final GAP cycle with pend>0: pend decrements. If trig=1 in the same cycle, increment and decrement cancel and pend is unchanged.
  - Saturation: if pend==2^PEND_WIDTH-1 and an increment is required with no simultaneous decrement, the event is dropped, pend holds, and ovf is set to 1.
- ovf:
  - Cleared by ovf_clr=1.
  - If set and clear occur in the same cycle, set wins and ovf=1.
- busy: registered, equal to (next state != IDLE).
- Counter wrap: cnt never wraps. It is always reloaded to 0 on a terminal count. For ON_CYCLES=1 or OFF_CYCLES=1 the terminal count is cnt==0, so the state lasts exactly one cycle.
- No combinational path from any input to any output.

Test Plan:
All cases use ON_CYCLES=4, OFF_CYCLES=3, PEND_WIDTH=2, WIDTH=4; cycle 0 is the cycle with trig=1.
- Single event: trig at cycle 0 -> O=1 in cycles 1-4, O=0 from cycle 5; busy=1 in cycles 1-7; IDLE and busy=0 at cycle 8; pend=0 throughout.
- Back-to-back events: trig at cycles 0 and 1 -> pend=1 at cycle 2; first pulse in cycles 1-4, gap in cycles 5-7, second pulse in cycles 8-11; pend=0 from cycle 8; IDLE at cycle 15.
- Trig on final gap cycle: trig at cycle 0 and again at cycle 7 -> second pulse in cycles 8-11 with no gap extension; pend stays 0.
- Saturation: trig at cycle 0 and five more trigs in cycles 1-3 and 5-6 -> pend reaches 3, ovf=1 after the fourth queued trig; exactly 4 pulses total; ovf_clr pulse clears ovf; ovf_clr together with a dropped trig leaves ovf=1.
- Reset mid-pulse: trig at cycle 0, rst_n low during cycle 2 -> O=0, pend=0, busy=0 immediately; after release, trig produces a normal full 4-cycle pulse.
- Simultaneous decrement and trig: with pend=2, trig on final GAP cycle -> next pulse starts and pend stays 2.
